// File: rtl/cic_pkg.sv
// Shared sizing, legality checks and output rounding for the CIC decimator.
package cic_pkg;

  // Widest accumulator the legal parameter range can produce (16 + 6*8), plus
  // headroom so the rounding offset can never overflow before the shift.
  localparam int WIDE = 66;

  function automatic int growth_f(input int r, input int n);
    return n * $clog2(r);
  endfunction

  function automatic int wacc_f(input int w_din, input int r, input int n);
    return w_din + growth_f(r, n);
  endfunction

  function automatic bit r_ok(input int r);
    return (r >= 2) && (r <= 256) && ((r & (r - 1)) == 0);
  endfunction

  function automatic bit n_ok(input int n);
    return (n >= 1) && (n <= 6);
  endfunction

  // Round half up, drop the CIC gain bits, then clamp to a w_out-bit signed range.
  function automatic logic signed [WIDE-1:0] round_sat(input logic signed [WIDE-1:0] x,
                                                       input int growth,
                                                       input int w_out);
    logic signed [WIDE-1:0] one;
    logic signed [WIDE-1:0] r;
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    one = {{(WIDE-1){1'b0}}, 1'b1};
    r   = (x + (one <<< (growth - 1))) >>> growth;
    hi  = (one <<< (w_out - 1)) - one;
    lo  = ~hi;
    if (r > hi)      return hi;
    else if (r < lo) return lo;
    else             return r;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb (differentiator) stage: y = x - previous x, one register stage,
// advancing only on a valid decimated sample.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_val,
  input  logic signed [W-1:0] x,
  output logic                out_val,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] x_dly;

  // Differentiate against the previous decimated sample; wraps modulo 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_dly   <= '0;
      y       <= '0;
      out_val <= 1'b0;
    end else begin
      out_val <= in_val;
      if (in_val) begin
        y     <= x - x_dly;
        x_dly <= x;
      end
    end
  end

endmodule

// File: rtl/cic_dec.sv
// N-stage CIC decimator by R with unity-gain rounded/saturated output.
module cic_dec
  import cic_pkg::*;
#(
  parameter int R      = 64,
  parameter int N      = 4,
  parameter int W_DIN  = 16,
  parameter int W_DOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [W_DIN-1:0]  din,
  input  logic                     din_val,
  output logic signed [W_DOUT-1:0] dout,
  output logic                     dout_val
);

  localparam int GROWTH = growth_f(R, N);
  localparam int WACC   = wacc_f(W_DIN, R, N);
  localparam int CW     = $clog2(R);

  if (!r_ok(R)) begin : g_bad_r
    $error("cic_dec: R must be a power of two in 2..256");
  end
  if (!n_ok(N)) begin : g_bad_n
    $error("cic_dec: N must be in 1..6");
  end

  logic signed [WACC-1:0] integ [N];
  logic [CW-1:0]          cnt;
  logic                   dec_stb;
  logic signed [WACC-1:0] samp;
  logic                   samp_val;
  logic signed [WACC-1:0] c_dat [N+1];
  logic [N:0]             c_val;

  // Integrator cascade; each stage adds the previous stage's registered value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else if (din_val) begin
      integ[0] <= integ[0] + WACC'(din);
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Count accepted samples; strobe once per R and capture the last integrator.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dec_stb  <= 1'b0;
      samp     <= '0;
      samp_val <= 1'b0;
    end else begin
      if (din_val) cnt <= cnt + 1'b1;
      dec_stb  <= din_val && (cnt == CW'(R - 1));
      samp_val <= dec_stb;
      if (dec_stb) samp <= integ[N-1];
    end
  end

  assign c_dat[0] = samp;
  assign c_val[0] = samp_val;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(.W(WACC)) u_comb (
      .clk     (clk),
      .rst     (rst),
      .in_val  (c_val[k]),
      .x       (c_dat[k]),
      .out_val (c_val[k+1]),
      .y       (c_dat[k+1])
    );
  end

  // Remove the R^N gain with rounding, clamp, and present a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_val <= 1'b0;
    end else begin
      dout_val <= c_val[N];
      if (c_val[N]) dout <= W_DOUT'(round_sat(WIDE'(c_dat[N]), GROWTH, W_DOUT));
    end
  end

endmodule
